// File: rtl/pong_pkg.sv
// Shared types, constants and helpers for the pong game blocks.
package pong_pkg;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, MISS} state_t;

  localparam int         FIELD_W = 16;
  localparam logic [3:0] CENTRE  = 4'd7;
  localparam logic [3:0] EDGE_LO = 4'd0;
  localparam logic [3:0] EDGE_HI = 4'(FIELD_W - 1);

  // Direction bit: 0 moves towards higher coordinates, 1 towards lower.
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // True when a paddle starting at p with the given length covers cell c.
  // Compared 5 bits wide so p+size-1 never wraps.
  function automatic logic covers(input logic [3:0] p, input logic [3:0] c,
                                  input logic [4:0] size);
    logic [4:0] lo;
    logic [4:0] hi;
    lo = {1'b0, p};
    hi = lo + size - 5'd1;
    return ({1'b0, c} >= lo) && ({1'b0, c} <= hi);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: one-cycle tick every `period` clocks; a shrinking
// period wraps the counter on the next cycle.
module tick_divider #(
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  assign last = period - CNT_W'(1);
  assign tick = (cnt == last);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt >= last) cnt <= '0;
    else                  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball motion: serve/play/miss sequencing, wall/paddle bounces, miss pulses.
// Optional macro BALL_SPEEDUP_EN shortens the tick period as paddle hits accumulate.
import pong_pkg::*;

module ball_engine #(
  parameter int WIDTH        = 16,
  parameter int BIT_OF_WIDTH = 4,
  parameter int SIZE         = 4,
  parameter int TICK_DIV     = 2000000,
  parameter int SERVE_TICKS  = 2,
  parameter int MISS_TICKS   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIT_OF_WIDTH-1:0]   player_top,
  input  logic [BIT_OF_WIDTH-1:0]   player_down,
  input  logic [BIT_OF_WIDTH-1:0]   player_left,
  input  logic [BIT_OF_WIDTH-1:0]   player_right,
  output logic [2*BIT_OF_WIDTH-1:0] pos_ball,
  output logic                      miss_top,
  output logic                      miss_down,
  output logic                      miss_left,
  output logic                      miss_right,
  output logic                      hit,
  output logic                      busy
);

  localparam int CNT_W  = $clog2(TICK_DIV + 1);
  localparam int PH_MAX = (SERVE_TICKS > MISS_TICKS) ? SERVE_TICKS : MISS_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [CNT_W-1:0]        DIV        = CNT_W'(TICK_DIV);
  localparam logic [PH_W-1:0]         SERVE_LAST = PH_W'(SERVE_TICKS - 1);
  localparam logic [PH_W-1:0]         MISS_LAST  = PH_W'(MISS_TICKS - 1);
  localparam logic [4:0]              PAD_LEN    = 5'(SIZE);
  localparam logic [BIT_OF_WIDTH-1:0] HI         = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [BIT_OF_WIDTH-1:0] ONE        = BIT_OF_WIDTH'(1);

  state_t                  state;
  logic [PH_W-1:0]         phase;
  logic [BIT_OF_WIDTH-1:0] x, y;
  logic                    dx, dy;
  logic [CNT_W-1:0]        period;
  logic                    tick;

  logic [BIT_OF_WIDTH-1:0] nx, ny, x_nxt, y_nxt;
  logic                    dx_nxt, dy_nxt;
  logic                    x_hit, y_hit, lose_l, lose_r, lose_t, lose_d;
  logic                    any_miss, any_hit;

  tick_divider #(.CNT_W(CNT_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .period (period),
    .tick   (tick)
  );

`ifdef BALL_SPEEDUP_EN
  logic [1:0] hit_cnt;
  logic       serve_entry;

  assign serve_entry = ((state == IDLE) && start) ||
                       ((state == MISS) && tick && (phase == MISS_LAST));
  assign period      = DIV >> (hit_cnt >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         hit_cnt <= 2'd0;
    else if (serve_entry)                               hit_cnt <= 2'd0;
    else if ((state == PLAY) && tick && any_hit && (hit_cnt != 2'd3))
                                                        hit_cnt <= hit_cnt + 2'd1;
  end
`else
  assign period = DIV;
`endif

  // Each axis is resolved on its own; a paddle edge either bounces or loses.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    nx     = (dx == DIR_NEG) ? x - ONE : x + ONE;
    ny     = (dy == DIR_NEG) ? y - ONE : y + ONE;
    x_nxt  = nx;
    y_nxt  = ny;
    dx_nxt = dx;
    dy_nxt = dy;
    x_hit  = 1'b0;
    y_hit  = 1'b0;
    lose_l = 1'b0;
    lose_r = 1'b0;
    lose_t = 1'b0;
    lose_d = 1'b0;

    if (nx == EDGE_LO) begin
      if (covers(player_left, y, PAD_LEN)) begin
        dx_nxt = DIR_POS; x_nxt = x + ONE; x_hit = 1'b1;
      end else begin
        lose_l = 1'b1; x_nxt = EDGE_LO;
      end
    end else if (nx == HI) begin
      if (covers(player_right, y, PAD_LEN)) begin
        dx_nxt = DIR_NEG; x_nxt = x - ONE; x_hit = 1'b1;
      end else begin
        lose_r = 1'b1; x_nxt = HI;
      end
    end

    if (ny == EDGE_LO) begin
      if (covers(player_top, x, PAD_LEN)) begin
        dy_nxt = DIR_POS; y_nxt = y + ONE; y_hit = 1'b1;
      end else begin
        lose_t = 1'b1; y_nxt = EDGE_LO;
      end
    end else if (ny == HI) begin
      if (covers(player_down, x, PAD_LEN)) begin
        dy_nxt = DIR_NEG; y_nxt = y - ONE; y_hit = 1'b1;
      end else begin
        lose_d = 1'b1; y_nxt = HI;
      end
    end
  end

  assign any_miss = lose_l | lose_r | lose_t | lose_d;
  assign any_hit  = (x_hit | y_hit) & ~any_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      x          <= CENTRE;
      y          <= CENTRE;
      dx         <= DIR_POS;
      dy         <= DIR_POS;
      hit        <= 1'b0;
      miss_top   <= 1'b0;
      miss_down  <= 1'b0;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
    end else begin
      // Pulses drop after one cycle unless re-armed below.
      hit        <= 1'b0;
      miss_top   <= 1'b0;
      miss_down  <= 1'b0;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SERVE;
          phase <= '0;
        end
        SERVE: if (tick) begin
          if (phase == SERVE_LAST) begin
            state <= PLAY;
            phase <= '0;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        PLAY: if (tick) begin
          x          <= x_nxt;
          y          <= y_nxt;
          dx         <= dx_nxt;
          dy         <= dy_nxt;
          hit        <= any_hit;
          miss_left  <= lose_l;
          miss_right <= lose_r;
          miss_top   <= lose_t;
          miss_down  <= lose_d;
          if (any_miss) begin
            state <= MISS;
            phase <= '0;
          end
        end
        MISS: if (tick) begin
          if (phase == MISS_LAST) begin
            state <= SERVE;
            phase <= '0;
            x     <= CENTRE;
            y     <= CENTRE;
            dx    <= ~dx;
            dy    <= ~dy;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pos_ball = {x, y};
  assign busy     = (state != IDLE);

endmodule
